// File: rtl/riscv_unicycle.sv
// Single-cycle RV32I-subset core: one instruction fetched, executed and retired per clock.
// Instruction ROM, data RAM and register file are internal; only clk/reset are pins.
module riscv_unicycle #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter string       IMEM_INIT  = "program.hex"
) (
  input  logic clk,
  input  logic reset
);

  localparam int unsigned IAW  = $clog2(IMEM_WORDS);
  localparam int unsigned DAW  = $clog2(DMEM_WORDS);
  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] regs [0:31];
  logic [XLEN-1:0] imem [0:IMEM_WORDS-1];
  logic [XLEN-1:0] dmem [0:DMEM_WORDS-1];

  logic [XLEN-1:0] instr, rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] ls_addr, dmem_rdata, wb_data, pc_d;
  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [DAW-1:0]  dmem_idx;
  logic            wb_en, st_en, taken;
  logic            unused_addr_bits;

  assign instr  = imem[IAW'(pc[31:2] % 30'(IMEM_WORDS))];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  // Loads and stores share one address adder; byte offset bits are dropped.
  assign ls_addr          = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign dmem_idx         = DAW'(ls_addr[31:2] % 30'(DMEM_WORDS));
  assign dmem_rdata       = dmem[dmem_idx];
  assign unused_addr_bits = ^{pc[1:0], ls_addr[1:0]};

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << sh;
      3'b010:  alu = {31'b0, ($signed(a) < $signed(b))};
      3'b011:  alu = {31'b0, (a < b)};
      3'b100:  alu = a ^ b;
      3'b101:  begin
        if (alt) alu = $signed(a) >>> sh;
        else     alu = a >> sh;
      end
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Decode/execute/next-PC; unsupported encodings fall through as pc+4 with no writes.
  always_comb begin
    pc_d    = pc + 32'd4;
    wb_en   = 1'b0;
    wb_data = '0;
    st_en   = 1'b0;
    taken   = 1'b0;
    case (opcode)
      OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
      OP_AUIPC: begin wb_en = 1'b1; wb_data = pc + imm_u; end
      OP_JAL:   begin wb_en = 1'b1; wb_data = pc + 32'd4; pc_d = pc + imm_j; end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc + 32'd4;
          pc_d    = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  taken = (rs1_val == rs2_val);
          3'b001:  taken = (rs1_val != rs2_val);
          3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
          3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  taken = (rs1_val <  rs2_val);
          3'b111:  taken = (rs1_val >= rs2_val);
          default: taken = 1'b0;
        endcase
        if (taken) pc_d = pc + imm_b;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin wb_en = 1'b1; wb_data = dmem_rdata; end
      end
      OP_STORE: st_en = (funct3 == 3'b010);
      OP_IMM: begin
        if (funct3 == 3'b001)      wb_en = (funct7 == 7'd0);
        else if (funct3 == 3'b101) wb_en = (funct7 == 7'd0) || (funct7 == F7_ALT);
        else                       wb_en = 1'b1;
        wb_data = alu(funct3, (funct3 == 3'b101) && funct7[5], rs1_val, imm_i);
      end
      OP_REG: begin
        wb_en   = (funct7 == 7'd0) ||
                  ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        wb_data = alu(funct3, funct7[5], rs1_val, rs2_val);
      end
      default: ;
    endcase
  end

  // Architectural state; a store is suppressed whenever reset is low at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= pc_d;
      if (wb_en && (rd != 5'd0)) regs[rd] <= wb_data;
      if (st_en) dmem[dmem_idx] <= rs2_val;
    end
  end

endmodule

// File: tb/tb_riscv_unicycle.sv
// Bench for riscv_unicycle: directed program vectors, reset/store corner sequences,
// and random programs compared against an instruction-level reference model.
module tb_riscv_unicycle;

  localparam int IMEM = 256;
  localparam int DMEM = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset;

  riscv_unicycle #(.IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM), .IMEM_INIT("")) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog_buf [0:63];
  logic [31:0] m_imem [0:IMEM-1];
  logic [31:0] m_dmem [0:DMEM-1];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;

  typedef struct packed {
    logic [11:0][31:0] prog;
    logic [3:0]        n;
    logic [9:0]        edges;
    logic [2:0][4:0]   ridx;
    logic [2:0][31:0]  rval;
    logic [31:0]       exp_pc;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---- tiny assembler ----
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    logic [11:0] m;
    m = 12'(imm);
    return {m, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    return enc_i(7'h13, 3'd0, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] rop(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input int imm);
    logic [11:0] m;
    m = 12'(imm);
    return {m[11:5], rs2, rs1, f3, m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input int off);
    logic [12:0] m;
    m = 13'(off);
    return {m[12], m[10:5], rs2, rs1, f3, m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input int off);
    logic [20:0] m;
    m = 21'(off);
    return {m[20], m[10:1], m[11], m[19:12], rd, 7'h6f};
  endfunction

  // ---- reference model: one architectural instruction per call ----
  task automatic model_step();
    logic [31:0] ins, a, b, immi, imms, immb, immj, immu, npc, wv, ea;
    logic [4:0]  rd, sh;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        wr, t;
    ins  = m_imem[int'((m_pc >> 2) % 32'(IMEM))];
    rd   = ins[11:7];
    f3   = ins[14:12];
    f7   = ins[31:25];
    a    = m_regs[ins[19:15]];
    b    = m_regs[ins[24:20]];
    immi = 32'($signed(ins[31:20]));
    imms = 32'($signed({ins[31:25], ins[11:7]}));
    immb = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    immj = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    immu = {ins[31:12], 12'h000};
    sh   = ins[24:20];
    npc  = m_pc + 32'd4;
    wr   = 1'b0;
    wv   = 32'd0;
    t    = 1'b0;
    case (ins[6:0])
      7'h37: begin wr = 1'b1; wv = immu; end
      7'h17: begin wr = 1'b1; wv = m_pc + immu; end
      7'h6f: begin wr = 1'b1; wv = m_pc + 32'd4; npc = m_pc + immj; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; wv = m_pc + 32'd4; npc = (a + immi) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) < $signed(b));
          3'd5: t = !($signed(a) < $signed(b));
          3'd6: t = (a < b);
          3'd7: t = !(a < b);
          default: t = 1'b0;
        endcase
        if (t) npc = m_pc + immb;
      end
      7'h03: if (f3 == 3'd2) begin
        ea = a + immi;
        wr = 1'b1;
        wv = m_dmem[int'((ea >> 2) % 32'(DMEM))];
      end
      7'h23: if (f3 == 3'd2) begin
        ea = a + imms;
        m_dmem[int'((ea >> 2) % 32'(DMEM))] = b;
      end
      7'h13: begin
        wr = 1'b1;
        case (f3)
          3'd0: wv = a + immi;
          3'd2: wv = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
          3'd3: wv = (a < immi) ? 32'd1 : 32'd0;
          3'd4: wv = a ^ immi;
          3'd6: wv = a | immi;
          3'd7: wv = a & immi;
          3'd1: begin wr = (f7 == 7'h00); wv = a << sh; end
          default: begin
            if (f7 == 7'h00)      wv = a >> sh;
            else if (f7 == 7'h20) wv = $signed(a) >>> sh;
            else                  wr = 1'b0;
          end
        endcase
      end
      7'h33: begin
        wr = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: wv = a + b;
            3'd1: wv = a << b[4:0];
            3'd2: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: wv = (a < b) ? 32'd1 : 32'd0;
            3'd4: wv = a ^ b;
            3'd5: wv = a >> b[4:0];
            3'd6: wv = a | b;
            default: wv = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) wv = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5)     wv = $signed(a) >>> b[4:0];
        else wr = 1'b0;
      end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_regs[rd] = wv;
    m_pc = npc;
  endtask

  // Hold reset, load prog_buf[0..n-1] (rest NOP) into DUT and model, release at a falling edge.
  task automatic load_prog(input int n);
    reset = 1'b0;
    #1;
    for (int i = 0; i < IMEM; i++) begin
      dut.imem[i] = (i < n) ? prog_buf[i] : NOP;
      m_imem[i]   = (i < n) ? prog_buf[i] : NOP;
    end
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 32'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [4:0] rnd_reg();
    return 5'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 31 : 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [6:0] f7;
    k = int'($urandom_range(0, 15));
    f7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
    case (k)
      0:  return enc_u(7'h37, rnd_reg(), 20'($urandom));
      1:  return enc_u(7'h17, rnd_reg(), 20'($urandom));
      2:  return enc_j(rnd_reg(), (int'($urandom_range(0, 32)) - 16) * 4);
      3:  return enc_i(7'h67, 3'd0, rnd_reg(), rnd_reg(), int'($urandom_range(0, 4095)));
      4:  return enc_b(3'($urandom), rnd_reg(), rnd_reg(), (int'($urandom_range(0, 32)) - 16) * 2);
      5, 6: return enc_i(7'h03, 3'd2, rnd_reg(), rnd_reg(), int'($urandom_range(0, 4095)));
      7, 8: return enc_s(3'd2, rnd_reg(), rnd_reg(), int'($urandom_range(0, 4095)));
      9, 10, 11: begin
        logic [2:0] f3;
        logic [31:0] w;
        f3 = 3'($urandom);
        w = enc_i(7'h13, f3, rnd_reg(), rnd_reg(), int'($urandom_range(0, 4095)));
        if (f3 == 3'd1 || f3 == 3'd5) w[31:25] = f7;
        return w;
      end
      12, 13, 14: return rop(f7, 3'($urandom), rnd_reg(), rnd_reg(), rnd_reg());
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset = 1'b0;

    // ---- directed program vectors ----
    v = '0;
    v.prog[0] = addi(1, 0, 5);   v.prog[1] = addi(2, 0, -3);
    v.prog[2] = rop(7'h00, 3'd0, 3, 1, 2);
    v.prog[3] = rop(7'h20, 3'd0, 4, 2, 1);
    v.prog[4] = rop(7'h00, 3'd2, 5, 2, 1);
    v.prog[5] = rop(7'h00, 3'd3, 6, 2, 1);
    v.prog[6] = enc_i(7'h13, 3'd5, 7, 2, 12'h401);
    v.n = 4'd7; v.edges = 10'd7; v.exp_pc = 32'd28;
    v.ridx[0] = 5'd3; v.rval[0] = 32'd2;
    v.ridx[1] = 5'd4; v.rval[1] = 32'hFFFF_FFF8;
    v.ridx[2] = 5'd5; v.rval[2] = 32'd1;
    vecs[0] = v;
    v.ridx[0] = 5'd6; v.rval[0] = 32'd0;
    v.ridx[1] = 5'd7; v.rval[1] = 32'hFFFF_FFFE;
    v.ridx[2] = 5'd1; v.rval[2] = 32'd5;
    vecs[1] = v;

    v = '0;
    v.prog[0] = enc_b(3'd0, 0, 0, 8);  v.prog[1] = addi(5, 0, 1);
    v.prog[2] = enc_j(1, 16);          v.prog[3] = addi(6, 0, 9);
    v.prog[4] = enc_b(3'd1, 0, 0, 8);  v.prog[5] = addi(5, 0, 2);
    v.prog[6] = enc_i(7'h67, 3'd0, 0, 1, 0);
    v.n = 4'd7; v.edges = 10'd5; v.exp_pc = 32'd20;
    v.ridx[0] = 5'd1; v.rval[0] = 32'd12;
    v.ridx[1] = 5'd5; v.rval[1] = 32'd0;
    v.ridx[2] = 5'd6; v.rval[2] = 32'd9;
    vecs[2] = v;

    v = '0;
    for (int i = 0; i < 12; i++) v.prog[i] = NOP;
    v.prog[0]  = addi(0, 0, 7);
    v.prog[1]  = enc_u(7'h37, 8, 20'h12345);
    v.prog[2]  = enc_j(0, 32);
    v.prog[10] = enc_u(7'h17, 9, 20'h00001);
    v.n = 4'd11; v.edges = 10'd4; v.exp_pc = 32'd44;
    v.ridx[0] = 5'd0; v.rval[0] = 32'd0;
    v.ridx[1] = 5'd8; v.rval[1] = 32'h1234_5000;
    v.ridx[2] = 5'd9; v.rval[2] = 32'h0000_1028;
    vecs[3] = v;

    v = '0;
    v.prog[0] = 32'h0000_0000; v.prog[1] = addi(1, 0, 3);
    v.n = 4'd2; v.edges = 10'd1; v.exp_pc = 32'd4;
    v.ridx[0] = 5'd1; v.rval[0] = 32'd0;
    vecs[4] = v;

    v = '0;
    v.prog[0] = addi(1, 0, 5);
    v.prog[1] = rop(7'h20, 3'd1, 2, 1, 1);
    v.prog[2] = enc_b(3'd2, 0, 0, 8);
    v.n = 4'd3; v.edges = 10'd3; v.exp_pc = 32'd12;
    v.ridx[0] = 5'd2; v.rval[0] = 32'd0;
    v.ridx[1] = 5'd1; v.rval[1] = 32'd5;
    vecs[5] = v;

    v = '0;
    v.prog[0] = addi(1, 0, -1);
    v.prog[1] = enc_i(7'h13, 3'd3, 2, 1, 1);
    v.prog[2] = enc_i(7'h13, 3'd2, 3, 1, 1);
    v.prog[3] = enc_i(7'h13, 3'd5, 4, 1, 28);
    v.n = 4'd4; v.edges = 10'd4; v.exp_pc = 32'd16;
    v.ridx[0] = 5'd2; v.rval[0] = 32'd0;
    v.ridx[1] = 5'd3; v.rval[1] = 32'd1;
    v.ridx[2] = 5'd4; v.rval[2] = 32'h0000_000F;
    vecs[6] = v;

    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 12; i++) prog_buf[i] = vecs[k].prog[i];
      load_prog(int'(vecs[k].n));
      repeat (int'(vecs[k].edges)) @(posedge clk);
      @(negedge clk);
      for (int j = 0; j < 3; j++)
        check($sformatf("vec%0d x%0d", k, vecs[k].ridx[j]), dut.regs[vecs[k].ridx[j]], vecs[k].rval[j]);
      check($sformatf("vec%0d pc", k), dut.pc, vecs[k].exp_pc);
    end

    // ---- store then load through the same address ----
    prog_buf[0] = addi(1, 0, 32'h40);  prog_buf[1] = addi(2, 0, 32'h123);
    prog_buf[2] = enc_s(3'd2, 1, 2, 4); prog_buf[3] = enc_i(7'h03, 3'd2, 3, 1, 4);
    load_prog(4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mem dmem17", dut.dmem[17], 32'h123);
    check("mem x3", dut.regs[3], 32'h123);
    check("mem pc", dut.pc, 32'd16);

    // ---- reset asserted mid-program clears state without an edge, then holds it ----
    prog_buf[0] = addi(1, 0, 5); prog_buf[1] = addi(2, 0, 7); prog_buf[2] = addi(3, 0, 9);
    load_prog(3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-reset x3", dut.regs[3], 32'd9);
    #2 reset = 1'b0;
    #1;
    check("async pc", dut.pc, 32'd0);
    check("async x1", dut.regs[1], 32'd0);
    check("async x3", dut.regs[3], 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d pc", c), dut.pc, 32'd0);
      for (int r = 1; r < 32; r++)
        check($sformatf("hold%0d x%0d", c, r), dut.regs[r], 32'd0);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release pc", dut.pc, 32'd4);
    check("release x1", dut.regs[1], 32'd5);
    check("release x2", dut.regs[2], 32'd0);

    // ---- no store while reset is low at the edge ----
    prog_buf[0] = addi(2, 0, 32'h55); prog_buf[1] = enc_s(3'd2, 0, 2, 0);
    load_prog(2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("st dmem0 set", dut.dmem[0], 32'h55);
    reset = 1'b0;
    #1 dut.imem[0] = enc_s(3'd2, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("st blocked", dut.dmem[0], 32'h55);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("st after release", dut.dmem[0], 32'd0);
    check("st pc", dut.pc, 32'd4);

    // ---- fill dmem with word i = 4*i so random loads see known data ----
    prog_buf[0] = addi(2, 0, 1024);     prog_buf[1] = enc_s(3'd2, 1, 1, 0);
    prog_buf[2] = addi(1, 1, 4);        prog_buf[3] = enc_b(3'd1, 1, 2, -8);
    load_prog(4);
    repeat (1 + 256 * 3) @(posedge clk);
    @(negedge clk);
    check("init pc", dut.pc, 32'd16);
    check("init x1", dut.regs[1], 32'd1024);
    check("init dmem255", dut.dmem[255], 32'd1020);
    for (int i = 0; i < DMEM; i++) m_dmem[i] = 32'(4 * i);

    // ---- random programs against the reference model ----
    for (int p = 0; p < 6; p++) begin
      int e0;
      for (int i = 0; i < 48; i++) prog_buf[i] = rand_instr();
      load_prog(48);
      e0 = errors;
      for (int s = 0; s < 150 && errors == e0; s++) begin
        model_step();
        @(posedge clk);
        @(negedge clk);
        check($sformatf("rand%0d step%0d pc", p, s), dut.pc, m_pc);
        for (int r = 0; r < 32; r++)
          check($sformatf("rand%0d step%0d x%0d", p, s, r), dut.regs[r], m_regs[r]);
      end
      for (int i = 0; i < DMEM && errors == e0; i++)
        check($sformatf("rand%0d dmem%0d", p, i), dut.dmem[i], m_dmem[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
